// File: rtl/exu_longpwbck.sv
// Long-pipe write-back/retire: classical loads to the CRF through a one-entry
// register, and per-qubit measurement reports merged per moitf entry for the MRF.
module exu_longpwbck #(
    parameter int XLEN      = 32,
    parameter int RFIDX_W   = 5,
    parameter int QUBIT_NUM = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lsu_rsp_valid,
    output logic                 lsu_rsp_ready,
    input  logic [XLEN-1:0]      lsu_rsp_rdata,
    input  logic                 oitf_empty,
    input  logic [RFIDX_W-1:0]   oitf_ret_rdidx,
    input  logic                 oitf_ret_rdwen,
    output logic                 oitf_ret_ena,
    output logic                 cwbck_o_valid,
    input  logic                 cwbck_o_ready,
    output logic [XLEN-1:0]      cwbck_o_data,
    output logic [RFIDX_W-1:0]   cwbck_o_rdidx,
    input  logic                 moitf_empty,
    input  logic [QUBIT_NUM-1:0] ret_mf,
    output logic                 moitf_ret_ena,
    input  logic                 mcu_i_valid,
    output logic                 mcu_i_ready,
    input  logic [QUBIT_NUM-1:0] mcu_i_qubit,
    input  logic [QUBIT_NUM-1:0] mcu_i_result,
    output logic                 mwbck_o_valid,
    input  logic                 mwbck_o_ready,
    output logic [QUBIT_NUM-1:0] mwbck_o_data,
    output logic [QUBIT_NUM-1:0] mwbck_o_mask,
    output logic                 meas_stray_o
);

    typedef enum logic [1:0] {M_IDLE, M_COLL, M_WB} mstate_e;

    // ---------------- classical path ----------------
    logic                cvld_q;
    logic [XLEN-1:0]     cdata_q;
    logic [RFIDX_W-1:0]  cidx_q;
    logic                lsu_acc;

    assign lsu_rsp_ready = !oitf_empty && (!cvld_q || cwbck_o_ready);
    assign lsu_acc       = lsu_rsp_valid && lsu_rsp_ready;
    assign oitf_ret_ena  = lsu_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cvld_q  <= 1'b0;
            cdata_q <= '0;
            cidx_q  <= '0;
        end else if (lsu_acc && oitf_ret_rdwen) begin
            cvld_q  <= 1'b1;
            cdata_q <= lsu_rsp_rdata;
            cidx_q  <= oitf_ret_rdidx;
        end else if (cwbck_o_ready) begin
            cvld_q  <= 1'b0;
        end
    end

    assign cwbck_o_valid = cvld_q;
    assign cwbck_o_data  = cdata_q;
    assign cwbck_o_rdidx = cidx_q;

    // ---------------- measurement path ----------------
    mstate_e              state_q;
    logic [QUBIT_NUM-1:0] tgt_q, got_q, mdata_q;
    logic                 stray_q;
    logic [QUBIT_NUM-1:0] hit, stray_bits;

    // Only qubits still owed by the current entry count; anything else is stray.
    assign hit        = mcu_i_qubit & tgt_q & ~got_q;
    assign stray_bits = mcu_i_qubit & ~(tgt_q & ~got_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= M_IDLE;
            tgt_q   <= '0;
            got_q   <= '0;
            mdata_q <= '0;
            stray_q <= 1'b0;
        end else begin
            stray_q <= 1'b0;
            case (state_q)
                M_IDLE: begin
                    if (!moitf_empty) begin
                        tgt_q   <= ret_mf;
                        got_q   <= '0;
                        mdata_q <= '0;
                        state_q <= (ret_mf == '0) ? M_WB : M_COLL;
                    end
                end
                M_COLL: begin
                    if (mcu_i_valid) begin
                        got_q   <= got_q | hit;
                        mdata_q <= (mdata_q & ~hit) | (mcu_i_result & hit);
                        stray_q <= |stray_bits;
                        if ((got_q | hit) == tgt_q) state_q <= M_WB;
                    end
                end
                M_WB: begin
                    if (mwbck_o_ready) state_q <= M_IDLE;
                end
                default: state_q <= M_IDLE;
            endcase
        end
    end

    assign mcu_i_ready   = (state_q == M_COLL);
    assign mwbck_o_valid = (state_q == M_WB);
    assign mwbck_o_data  = mdata_q;
    assign mwbck_o_mask  = tgt_q;
    assign moitf_ret_ena = (state_q == M_WB) && mwbck_o_ready;
    assign meas_stray_o  = stray_q;

endmodule

// File: tb/tb_exu_longpwbck.sv
// Directed bench for exu_longpwbck: classical write-back and measurement merge.
module tb_exu_longpwbck;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        oitf_empty;
    logic [4:0]  oitf_ret_rdidx;
    logic        oitf_ret_rdwen, oitf_ret_ena;
    logic        cwbck_o_valid, cwbck_o_ready;
    logic [31:0] cwbck_o_data;
    logic [4:0]  cwbck_o_rdidx;
    logic        moitf_empty;
    logic [7:0]  ret_mf;
    logic        moitf_ret_ena;
    logic        mcu_i_valid, mcu_i_ready;
    logic [7:0]  mcu_i_qubit, mcu_i_result;
    logic        mwbck_o_valid, mwbck_o_ready;
    logic [7:0]  mwbck_o_data, mwbck_o_mask;
    logic        meas_stray_o;

    int n_tests = 0;
    int n_fail  = 0;
    int mret_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (moitf_ret_ena) mret_cnt++;

    exu_longpwbck dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata), .oitf_empty(oitf_empty),
        .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_rdwen(oitf_ret_rdwen),
        .oitf_ret_ena(oitf_ret_ena), .cwbck_o_valid(cwbck_o_valid),
        .cwbck_o_ready(cwbck_o_ready), .cwbck_o_data(cwbck_o_data),
        .cwbck_o_rdidx(cwbck_o_rdidx), .moitf_empty(moitf_empty),
        .ret_mf(ret_mf), .moitf_ret_ena(moitf_ret_ena),
        .mcu_i_valid(mcu_i_valid), .mcu_i_ready(mcu_i_ready),
        .mcu_i_qubit(mcu_i_qubit), .mcu_i_result(mcu_i_result),
        .mwbck_o_valid(mwbck_o_valid), .mwbck_o_ready(mwbck_o_ready),
        .mwbck_o_data(mwbck_o_data), .mwbck_o_mask(mwbck_o_mask),
        .meas_stray_o(meas_stray_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; lsu_rsp_valid = 0; lsu_rsp_rdata = '0; oitf_empty = 1;
        oitf_ret_rdidx = '0; oitf_ret_rdwen = 0; cwbck_o_ready = 0;
        moitf_empty = 1; ret_mf = '0; mcu_i_valid = 0; mcu_i_qubit = '0;
        mcu_i_result = '0; mwbck_o_ready = 0;
        #12;
        chk("rst_cvld",  32'(cwbck_o_valid), 0);
        chk("rst_mvld",  32'(mwbck_o_valid), 0);
        chk("rst_stray", 32'(meas_stray_o), 0);
        chk("rst_mrdy",  32'(mcu_i_ready), 0);
        chk("rst_lrdy",  32'(lsu_rsp_ready), 0);
        rst_n = 1'b1;
        step();

        // classical: single load
        oitf_empty = 0; oitf_ret_rdidx = 5; oitf_ret_rdwen = 1; cwbck_o_ready = 1;
        lsu_rsp_valid = 1; lsu_rsp_rdata = 32'h1234_5678;
        #1;
        chk("c1_ready", 32'(lsu_rsp_ready), 1);
        chk("c1_ret",   32'(oitf_ret_ena), 1);
        step();
        chk("c1_vld",  32'(cwbck_o_valid), 1);
        chk("c1_data", cwbck_o_data, 32'h1234_5678);
        chk("c1_idx",  32'(cwbck_o_rdidx), 5);

        // stall while write-back port is busy
        cwbck_o_ready = 0; lsu_rsp_rdata = 32'hAAAA_0001; oitf_ret_rdidx = 7;
        #1;
        chk("st_ready", 32'(lsu_rsp_ready), 0);
        chk("st_ret",   32'(oitf_ret_ena), 0);
        step();
        chk("st_data", cwbck_o_data, 32'h1234_5678);
        chk("st_vld",  32'(cwbck_o_valid), 1);
        cwbck_o_ready = 1;
        #1;
        chk("b2b0_ret", 32'(oitf_ret_ena), 1);
        step();
        chk("b2b1_data", cwbck_o_data, 32'hAAAA_0001);
        chk("b2b1_idx",  32'(cwbck_o_rdidx), 7);
        lsu_rsp_rdata = 32'hBBBB_0002; oitf_ret_rdidx = 9;
        #1;
        chk("b2b2_ret", 32'(oitf_ret_ena), 1);
        step();
        chk("b2b2_data", cwbck_o_data, 32'hBBBB_0002);
        chk("b2b2_vld",  32'(cwbck_o_valid), 1);
        // rdwen=0: retire, no write-back
        oitf_ret_rdwen = 0; lsu_rsp_rdata = 32'hCCCC_0003; oitf_ret_rdidx = 3;
        #1;
        chk("nw_ret", 32'(oitf_ret_ena), 1);
        step();
        chk("nw_vld",  32'(cwbck_o_valid), 0);
        chk("nw_data", cwbck_o_data, 32'hBBBB_0002);
        // response with empty oitf is held off
        oitf_empty = 1;
        #1;
        chk("emp_ready", 32'(lsu_rsp_ready), 0);
        chk("emp_ret",   32'(oitf_ret_ena), 0);
        step();
        chk("emp_vld", 32'(cwbck_o_valid), 0);
        lsu_rsp_valid = 0; oitf_ret_rdwen = 1;

        // measurement: two single-qubit beats
        moitf_empty = 0; ret_mf = 8'b0000_0110;
        step();
        moitf_empty = 1;
        chk("m1_coll_rdy", 32'(mcu_i_ready), 1);
        mcu_i_valid = 1; mcu_i_qubit = 8'b0000_0010; mcu_i_result = 8'b0000_0010;
        step();
        chk("m1_b1_stray", 32'(meas_stray_o), 0);
        chk("m1_b1_mvld",  32'(mwbck_o_valid), 0);
        mcu_i_qubit = 8'b0000_0100; mcu_i_result = 8'b0000_0000;
        step();
        mcu_i_valid = 0;
        chk("m1_mvld", 32'(mwbck_o_valid), 1);
        chk("m1_data", 32'(mwbck_o_data), 32'h02);
        chk("m1_mask", 32'(mwbck_o_mask), 32'h06);
        chk("m1_wb_rdy", 32'(mcu_i_ready), 0);
        chk("m1_noret", 32'(moitf_ret_ena), 0);
        step();
        chk("m1_hold", 32'(mwbck_o_valid), 1);
        mwbck_o_ready = 1;
        #1;
        chk("m1_ret", 32'(moitf_ret_ena), 1);
        step();
        chk("m1_idle_vld", 32'(mwbck_o_valid), 0);
        chk("m1_idle_ret", 32'(moitf_ret_ena), 0);
        mwbck_o_ready = 0;

        // stray reports
        moitf_empty = 0; ret_mf = 8'b0000_0110;
        step();
        moitf_empty = 1;
        mcu_i_valid = 1; mcu_i_qubit = 8'b0000_1010; mcu_i_result = 8'b0000_1010;
        step();
        chk("s1_stray", 32'(meas_stray_o), 1);
        chk("s1_coll",  32'(mcu_i_ready), 1);
        mcu_i_qubit = 8'b0000_0010; mcu_i_result = 8'b0000_0000;
        step();
        chk("s2_stray", 32'(meas_stray_o), 1);
        mcu_i_valid = 0;
        step();
        chk("s3_nostray", 32'(meas_stray_o), 0);
        mcu_i_valid = 1; mcu_i_qubit = 8'b0000_0100; mcu_i_result = 8'b0000_0100;
        step();
        mcu_i_valid = 0;
        chk("s4_stray", 32'(meas_stray_o), 0);
        chk("s4_mvld",  32'(mwbck_o_valid), 1);
        chk("s4_data",  32'(mwbck_o_data), 32'h06);
        chk("s4_mask",  32'(mwbck_o_mask), 32'h06);
        mwbck_o_ready = 1;
        step();
        mwbck_o_ready = 0;
        chk("s4_idle", 32'(mwbck_o_valid), 0);

        // empty measure list goes straight to write-back
        moitf_empty = 0; ret_mf = 8'h00;
        step();
        moitf_empty = 1;
        chk("z_mvld", 32'(mwbck_o_valid), 1);
        chk("z_mask", 32'(mwbck_o_mask), 0);
        chk("z_data", 32'(mwbck_o_data), 0);
        chk("z_rdy",  32'(mcu_i_ready), 0);
        mwbck_o_ready = 1;
        #1;
        chk("z_ret", 32'(moitf_ret_ena), 1);
        step();
        mwbck_o_ready = 0;
        chk("z_idle", 32'(mwbck_o_valid), 0);

        // reset mid-collection, with a classical write-back pending
        moitf_empty = 0; ret_mf = 8'h81;
        oitf_empty = 0; lsu_rsp_valid = 1; lsu_rsp_rdata = 32'hDEAD_BEEF;
        oitf_ret_rdidx = 2; cwbck_o_ready = 0;
        step();
        lsu_rsp_valid = 0; oitf_empty = 1; moitf_empty = 1;
        chk("r_cvld", 32'(cwbck_o_valid), 1);
        mcu_i_valid = 1; mcu_i_qubit = 8'h01; mcu_i_result = 8'h01;
        step();
        mcu_i_valid = 0;
        chk("r_coll", 32'(mcu_i_ready), 1);
        mret_cnt = 0;
        mwbck_o_ready = 1;
        rst_n = 1'b0;
        #1;
        chk("r_mrdy",  32'(mcu_i_ready), 0);
        chk("r_mvld",  32'(mwbck_o_valid), 0);
        chk("r_cvld0", 32'(cwbck_o_valid), 0);
        chk("r_cdata", cwbck_o_data, 0);
        chk("r_mask",  32'(mwbck_o_mask), 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("r_idle_mvld", 32'(mwbck_o_valid), 0);
        chk("r_noret", 32'(mret_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
